wb_regfile: RTL and testbench
=============================

# wb_regfile

Write-back stage and architectural register file for the 5-stage pipeline. It takes the registered outputs of the MEM/WB pipeline register and selects the write-back data (ALU result or data-memory read data). It commits that data to a 2^ASIZE-entry register file and serves the two ID-stage read ports. Same-cycle write-to-read bypass is included, so the ID stage never needs a separate WB forwarding path.

## Interface
Parameters:
- DSIZE, 16, data width (register and bus width)
- ASIZE, 4, register address width; register file depth = 2^ASIZE
- CSIZE, 16, width of the committed-write counter

Ports (reset is synchronous, active-low):
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-low reset; sampled on rising clk only
- alu_result_in_WB  input  DSIZE  ALU result from MEM/WB register
- rdata_DM_in_WB  input  DSIZE  data-memory read data from MEM/WB register
- memToReg_in_WB  input  1  1 = write back rdata_DM_in_WB, 0 = alu_result_in_WB
- WriteEn_in_WB  input  1  register write request this cycle
- waddr_in_WB  input  ASIZE  destination register
- raddr1_ID  input  ASIZE  read port 1 address
- raddr2_ID  input  ASIZE  read port 2 address
- rdata1_ID  output  DSIZE  read port 1 data (combinational)
- rdata2_ID  output  DSIZE  read port 2 data (combinational)
- wdata_out_WB  output  DSIZE  selected write-back data (combinational, for trace/forwarding)
- wb_commit  output  1  registered pulse: a write committed on the previous edge
- wb_count  output  CSIZE  registered count of committed writes

## Operation
- wdata = memToReg_in_WB ? rdata_DM_in_WB : alu_result_in_WB. wdata_out_WB always equals wdata, independent of rst.
- Commit condition: rst==1 && WriteEn_in_WB==1 && waddr_in_WB!=0. On the rising edge with commit true:
  - reg[waddr_in_WB] <= wdata
  - wb_commit <= 1
  - wb_count <= wb_count+1, modulo 2^CSIZE (wraps from all-ones to 0, no saturation)
- Otherwise, with rst==1: no register changes, wb_commit <= 0, and wb_count holds.
- Register 0 is hardwired to zero. Writes to it are discarded and do not set wb_commit or increment wb_count.
- Read port n (identical for both ports, evaluated independently):
  - rst==0 → 0
  - else raddr==0 → 0
  - else WriteEn_in_WB && waddr_in_WB==raddr → wdata (write-through bypass)
  - else reg[raddr]
- Both ports may address the same register, and both may hit the bypass in the same cycle.
- Reset, on a rising edge with rst==0:
  - all 2^ASIZE registers <= 0, wb_commit <= 0, wb_count <= 0
  - any simultaneous write request is dropped, not counted, and not bypassed
- Reset deasserted mid-stream: the first edge with rst==1 commits normally. No warm-up cycle.

## Timing
- Write latency: data presented in cycle N is in the array after edge N and readable without bypass from cycle N+1. In cycle N itself it is visible on the read ports via bypass (zero-cycle read-after-write).
- Read ports and wdata_out_WB are purely combinational from the inputs and array state; there is no clock-to-out register.
- wb_commit and wb_count reflect the edge that performed the commit. They are valid from cycle N+1 for a commit in cycle N.
- Reset values: every register 0, wb_commit 0, wb_count 0. rdata1_ID and rdata2_ID are 0 while rst==0. wdata_out_WB follows its inputs.
- No handshake: one write request per cycle maximum, always accepted when the commit condition holds.

## Test plan
- Reset: hold rst=0 for 2 edges with WriteEn=1, waddr=3, alu=16'h1234 → reg3 reads 0 after release, wb_count=0, wb_commit=0, rdata1/2=0 during reset.
- ALU vs memory select: cycle 1 write reg5 with memToReg=0, alu=16'hAAAA, DM=16'h5555 → reg5=16'hAAAA. Cycle 2 write reg6 with memToReg=1, same data → reg6=16'h5555. wb_count=2; wb_commit high on cycles 2 and 3.
- Bypass: WriteEn=1, waddr=7, wdata=16'hBEEF, raddr1=raddr2=7 in the same cycle → both read 16'hBEEF while reg7 still holds its old value. Next cycle without a write → both read 16'hBEEF from the array.
- Register 0: WriteEn=1, waddr=0, alu=16'hFFFF → rdata with raddr=0 stays 0, including in the write cycle. wb_commit=0; wb_count unchanged.
- Counter wrap: set CSIZE=4 and perform 17 commits → wb_count=1. Interleave WriteEn=0 cycles → no increment on those cycles.
- Reset mid-operation: after writes to reg1..reg15, drive rst=0 for one edge concurrently with a write to reg2 → all registers read 0 afterwards and wb_count=0. The next write to reg2 commits with no idle cycle.

Source files
------------

// File: rtl/wb_regfile.sv
// Write-back stage: selects the write-back data, commits it to the architectural
// register file and serves the two ID-stage read ports with same-cycle bypass.
module wb_regfile #(
    parameter int unsigned DSIZE = 16,
    parameter int unsigned ASIZE = 4,
    parameter int unsigned CSIZE = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DSIZE-1:0] alu_result_in_WB,
    input  logic [DSIZE-1:0] rdata_DM_in_WB,
    input  logic             memToReg_in_WB,
    input  logic             WriteEn_in_WB,
    input  logic [ASIZE-1:0] waddr_in_WB,
    input  logic [ASIZE-1:0] raddr1_ID,
    input  logic [ASIZE-1:0] raddr2_ID,
    output logic [DSIZE-1:0] rdata1_ID,
    output logic [DSIZE-1:0] rdata2_ID,
    output logic [DSIZE-1:0] wdata_out_WB,
    output logic             wb_commit,
    output logic [CSIZE-1:0] wb_count
);

    localparam int unsigned Depth = 1 << ASIZE;

    logic [DSIZE-1:0] regs_q [Depth];
    logic [DSIZE-1:0] regs_d [Depth];
    logic             commit_q, commit_d;
    logic [CSIZE-1:0] count_q, count_d;
    logic [DSIZE-1:0] wdata;
    logic             commit;

    // Write-back mux and commit qualification; register 0 is never written.
    always_comb begin
        wdata  = memToReg_in_WB ? rdata_DM_in_WB : alu_result_in_WB;
        commit = rst && WriteEn_in_WB && (waddr_in_WB != '0);
    end

    // Next-state for the array, the commit pulse and the commit counter.
    always_comb begin
        regs_d   = regs_q;
        commit_d = 1'b0;
        count_d  = count_q;
        if (commit) begin
            regs_d[waddr_in_WB] = wdata;
            commit_d            = 1'b1;
            count_d             = count_q + CSIZE'(1);
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < Depth; i++) begin
                regs_q[i] <= '0;
            end
            commit_q <= 1'b0;
            count_q  <= '0;
        end else begin
            regs_q   <= regs_d;
            commit_q <= commit_d;
            count_q  <= count_d;
        end
    end

    // Read port 1: reset and r0 force zero, then bypass, then array.
    always_comb begin
        rdata1_ID = '0;
        if (rst && (raddr1_ID != '0)) begin
            if (WriteEn_in_WB && (waddr_in_WB == raddr1_ID)) begin
                rdata1_ID = wdata;
            end else begin
                rdata1_ID = regs_q[raddr1_ID];
            end
        end
    end

    // Read port 2: same rules as port 1, evaluated independently.
    always_comb begin
        rdata2_ID = '0;
        if (rst && (raddr2_ID != '0)) begin
            if (WriteEn_in_WB && (waddr_in_WB == raddr2_ID)) begin
                rdata2_ID = wdata;
            end else begin
                rdata2_ID = regs_q[raddr2_ID];
            end
        end
    end

    assign wdata_out_WB = wdata;
    assign wb_commit    = commit_q;
    assign wb_count     = count_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: the driver pushes expected outputs per cycle,
// a monitor pops and compares them late in the same cycle.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        we, mtr;
    logic [3:0]  wa, ra1, ra2;
    logic [15:0] alu, dm;
    logic [15:0] r1, r2, wd, cnt16;
    logic        cm;
    logic [15:0] r1b, r2b, wdb;
    logic        cmb;
    logic [3:0]  cnt4;

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk(clk), .rst(rst), .alu_result_in_WB(alu), .rdata_DM_in_WB(dm),
        .memToReg_in_WB(mtr), .WriteEn_in_WB(we), .waddr_in_WB(wa),
        .raddr1_ID(ra1), .raddr2_ID(ra2), .rdata1_ID(r1), .rdata2_ID(r2),
        .wdata_out_WB(wd), .wb_commit(cm), .wb_count(cnt16)
    );

    // Narrow-counter instance sharing all stimulus, used for the wrap checks.
    wb_regfile #(.DSIZE(16), .ASIZE(4), .CSIZE(4)) dut4 (
        .clk(clk), .rst(rst), .alu_result_in_WB(alu), .rdata_DM_in_WB(dm),
        .memToReg_in_WB(mtr), .WriteEn_in_WB(we), .waddr_in_WB(wa),
        .raddr1_ID(ra1), .raddr2_ID(ra2), .rdata1_ID(r1b), .rdata2_ID(r2b),
        .wdata_out_WB(wdb), .wb_commit(cmb), .wb_count(cnt4)
    );

    typedef struct {
        logic [15:0] r1, r2, wd, cnt;
        logic        cm;
        logic [3:0]  cnt4;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   tests  = 0;
    int   failed = 0;

    // Reference model: plain array of register values, commit flag, count.
    int unsigned mdl [16];
    bit          m_cm;
    int unsigned m_cnt;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare whatever the driver pushed for this cycle, just before the edge.
    always @(negedge clk) begin
        #4;
        if (q.size() != 0) begin
            e = q.pop_front();
            check("rdata1", r1, e.r1);
            check("rdata2", r2, e.r2);
            check("wdata", wd, e.wd);
            check("wb_commit", {15'd0, cm}, {15'd0, e.cm});
            check("wb_count", cnt16, e.cnt);
            check("rdata1_c4", r1b, e.r1);
            check("wb_commit_c4", {15'd0, cmb}, {15'd0, e.cm});
            check("wb_count_c4", {12'd0, cnt4}, {12'd0, e.cnt4});
        end
    end

    function automatic logic [15:0] model_read(input logic r, input logic w,
                                               input logic [3:0] a, input logic [15:0] wdat,
                                               input logic [3:0] ra);
        if (!r || ra == 4'd0) return 16'd0;
        if (w && a == ra) return wdat;
        return mdl[ra][15:0];
    endfunction

    task automatic cycle(input logic r, input logic w, input logic [3:0] a,
                         input logic [15:0] al, input logic [15:0] d, input logic mm,
                         input logic [3:0] a1, input logic [3:0] a2);
        exp_t        x;
        logic [15:0] wdat;
        int unsigned c;
        @(negedge clk);
        #1;
        rst = r; we = w; wa = a; alu = al; dm = d; mtr = mm; ra1 = a1; ra2 = a2;
        wdat   = mm ? d : al;
        x.r1   = model_read(r, w, a, wdat, a1);
        x.r2   = model_read(r, w, a, wdat, a2);
        x.wd   = wdat;
        x.cm   = m_cm;
        c      = m_cnt % 65536;
        x.cnt  = c[15:0];
        c      = m_cnt % 16;
        x.cnt4 = c[3:0];
        q.push_back(x);
        // Effect of the coming rising edge.
        if (!r) begin
            foreach (mdl[i]) mdl[i] = 0;
            m_cm  = 1'b0;
            m_cnt = 0;
        end else begin
            m_cm = w && (a != 4'd0);
            if (m_cm) begin
                mdl[a] = {16'd0, wdat};
                m_cnt++;
            end
        end
    endtask

    initial begin
        rst = 1'b0; we = 1'b0; wa = '0; alu = '0; dm = '0; mtr = 1'b0; ra1 = '0; ra2 = '0;
        repeat (2) @(posedge clk);
        foreach (mdl[i]) mdl[i] = 0;
        m_cm = 1'b0; m_cnt = 0;

        // Reset with a pending write: dropped, reads zero.
        cycle(0, 1, 3, 16'h1234, 0, 0, 3, 3);
        cycle(0, 1, 3, 16'h1234, 0, 0, 3, 3);
        cycle(1, 0, 0, 0, 0, 0, 3, 0);
        // ALU vs memory select.
        cycle(1, 1, 5, 16'hAAAA, 16'h5555, 0, 5, 6);
        cycle(1, 1, 6, 16'hAAAA, 16'h5555, 1, 5, 6);
        cycle(1, 0, 0, 0, 0, 0, 5, 6);
        // Bypass on both ports, then array read.
        cycle(1, 1, 7, 16'hBEEF, 0, 0, 7, 7);
        cycle(1, 0, 0, 0, 0, 0, 7, 7);
        // Register 0 write discarded.
        cycle(1, 1, 0, 16'hFFFF, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        // Counter wrap on the 4-bit instance: 17 commits from reset.
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 17; i++) begin
            cycle(1, 1, 4'(1 + i % 15), 16'($urandom), 16'($urandom), 1'($urandom), 4'(i), 4'(i + 1));
            cycle(1, 0, 4'(1 + i % 15), 16'($urandom), 0, 0, 4'(i + 2), 4'(i + 3));
        end
        // Mid-stream reset against a write to reg2, then immediate commit.
        for (int i = 1; i < 16; i++) cycle(1, 1, 4'(i), 16'($urandom), 0, 0, 4'(i), 4'(i - 1));
        cycle(0, 1, 2, 16'h7777, 0, 0, 2, 2);
        cycle(1, 1, 2, 16'h4242, 0, 0, 2, 3);
        for (int i = 0; i < 16; i++) cycle(1, 0, 0, 0, 0, 0, 4'(i), 4'(15 - i));
        // Randomized traffic with occasional reset.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 39) != 0), 1'($urandom), 4'($urandom), 16'($urandom),
                  16'($urandom), 1'($urandom), 4'($urandom), 4'($urandom));
        end
        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            tests++;
            failed++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
